// File: rtl/fp_int_mul_bitserial.sv
// ---------------------------------------------------------------------------
// fp_int_mul_bitserial
//   Multiplies an FP16 activation by a bit-serial integer weight (MSB first).
//   The activation's significand {hidden, mantissa} is shift-and-add
//   accumulated against the weight bits; the activation exponent passes
//   through unchanged. The result is sign/magnitude: out_mant is an unsigned
//   fixed-point magnitude with 10 fraction bits.
//
// Configuration macro:
//   FP_INT_MUL_UNSIGNED_W_EN - adds input w_unsigned; when latched high the
//                              weight is treated as unsigned (MSB adds).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  activation + precision offer (ready only in IDLE)
//   act             FP16 activation
//   precision       weight bit count (clamped to 2..MAX_PREC)
//   w_bit/w_valid   serial weight bit and its qualifier
//   out_valid/ready result handshake
//   out_sign        product sign
//   out_exp         activation exponent
//   out_mant        product magnitude (MANT_W bits, 10 fraction bits)
// ---------------------------------------------------------------------------
module fp_int_mul_bitserial #(
  parameter int ACT_WIDTH = 16,
  parameter int MAX_PREC  = 8,
  parameter int MANT_W    = 11 + MAX_PREC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] act,
  input  logic [3:0]           precision,
`ifdef FP_INT_MUL_UNSIGNED_W_EN
  input  logic                 w_unsigned,
`endif
  input  logic                 w_bit,
  input  logic                 w_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [4:0]           out_exp,
  output logic [MANT_W-1:0]    out_mant
);

  localparam logic [3:0] MAX_PREC_C = 4'(MAX_PREC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_r;
  logic [ACT_WIDTH-1:0]   act_r;
  logic [3:0]             prec_r;
  logic [3:0]             cnt_r;
  // Two's complement accumulator; one bit wider than the output magnitude.
  logic [MANT_W:0]        acc_r;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic                   out_sign_r;
  logic [4:0]             out_exp_r;
  logic [MANT_W-1:0]      out_mant_r;
  logic                   w_uns_s;

  logic [3:0]             eff_prec_s;
  logic [10:0]            m_s;
  logic [MANT_W:0]        term_s;
  logic [MANT_W:0]        acc_shift_s;
  logic [MANT_W:0]        acc_next_s;
  logic [3:0]             cnt_next_s;
  logic                   last_bit_s;
  logic                   sub_first_s;
  logic [MANT_W-1:0]      mag_s;
  logic                   sign_s;

`ifdef FP_INT_MUL_UNSIGNED_W_EN
  logic                   w_uns_r;
  assign w_uns_s = w_uns_r;
`else
  assign w_uns_s = 1'b0;
`endif

  // Clamp the requested precision into the legal 2..MAX_PREC range.
  always_comb begin
    eff_prec_s = precision;
    if (precision < 4'd2) begin
      eff_prec_s = 4'd2;
    end else if (precision > MAX_PREC_C) begin
      eff_prec_s = MAX_PREC_C;
    end else begin
      eff_prec_s = precision;
    end
  end

  // Next accumulator value for the current weight bit, plus the result view.
  always_comb begin
    // Hidden bit is 0 for zero/subnormal activations.
    m_s         = {(act_r[14:10] != 5'd0), act_r[9:0]};
    acc_shift_s = {acc_r[MANT_W-1:0], 1'b0};
    term_s      = {(MANT_W+1){1'b0}};
    if (w_bit) begin
      term_s = {{(MANT_W-10){1'b0}}, m_s};
    end else begin
      term_s = {(MANT_W+1){1'b0}};
    end
    // The weight MSB carries negative weight unless the weight is unsigned.
    sub_first_s = (cnt_r == 4'd0) && !w_uns_s;
    if (sub_first_s) begin
      acc_next_s = acc_shift_s - term_s;
    end else begin
      acc_next_s = acc_shift_s + term_s;
    end
    cnt_next_s = cnt_r + 4'd1;
    last_bit_s = (cnt_next_s == prec_r);
    // Magnitude always fits MANT_W bits, so negating the low bits suffices.
    if (acc_next_s[MANT_W]) begin
      mag_s = ~acc_next_s[MANT_W-1:0] + {{(MANT_W-1){1'b0}}, 1'b1};
    end else begin
      mag_s = acc_next_s[MANT_W-1:0];
    end
    if (mag_s == {MANT_W{1'b0}}) begin
      sign_s = 1'b0;
    end else begin
      sign_s = act_r[ACT_WIDTH-1] ^ acc_next_s[MANT_W];
    end
  end

  // Control FSM with datapath state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      act_r       <= {ACT_WIDTH{1'b0}};
      prec_r      <= 4'd2;
      cnt_r       <= 4'd0;
      acc_r       <= {(MANT_W+1){1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sign_r  <= 1'b0;
      out_exp_r   <= 5'd0;
      out_mant_r  <= {MANT_W{1'b0}};
`ifdef FP_INT_MUL_UNSIGNED_W_EN
      w_uns_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            act_r      <= act;
            prec_r     <= eff_prec_s;
            cnt_r      <= 4'd0;
            acc_r      <= {(MANT_W+1){1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= ST_ACCUM;
`ifdef FP_INT_MUL_UNSIGNED_W_EN
            w_uns_r    <= w_unsigned;
`endif
          end
        end
        ST_ACCUM: begin
          // w_valid low is a stall: everything holds.
          if (w_valid) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_next_s;
            if (last_bit_s) begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              out_mant_r  <= mag_s;
              out_sign_r  <= sign_s;
              out_exp_r   <= act_r[14:10];
            end
          end
        end
        ST_DONE: begin
          // No bypass: in_ready rises only once back in IDLE.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sign  = out_sign_r;
  assign out_exp   = out_exp_r;
  assign out_mant  = out_mant_r;

endmodule

// File: doc/fp_int_mul_bitserial.md
FP_INT_MUL_BITSERIAL -- requirements
Module: fp_int_mul_bitserial

Interface
REQ-001 Parameter ACT_WIDTH, default 16, FP16 activation width (1 sign, 5 exponent, 10 mantissa).
REQ-002 Parameter MAX_PREC, default 8, maximum weight precision in bits (legal 2..15).
REQ-003 Parameter MANT_W, default 11+MAX_PREC, output magnitude width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  activation/precision offer.
REQ-007 in_ready  out  1  high only in IDLE.
REQ-008 act  in  ACT_WIDTH  FP16 activation.
REQ-009 precision  in  4  weight bit count for this operation.
REQ-010 w_bit  in  1  serial weight bit, MSB first.
REQ-011 w_valid  in  1  w_bit qualifier.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  result accepted.
REQ-014 out_sign  out  1  product sign.
REQ-015 out_exp  out  5  product exponent (activation exponent, unmodified).
REQ-016 out_mant  out  MANT_W  product magnitude, unsigned fixed point, 10 fraction bits.

Function
REQ-017 FSM states IDLE, ACCUM, DONE; reset state IDLE.
REQ-018 IDLE: in_valid=1 latches act and effective precision, clears accumulator and bit counter, moves to ACCUM next cycle.
REQ-019 Effective precision: value <2 treated as 2; value >MAX_PREC treated as MAX_PREC.
REQ-020 Multiplicand m = {hidden,act[9:0]}, hidden = 1 when act exponent != 0, else 0 (subnormal/zero).
REQ-021 ACCUM, w_valid=1: acc <= 2*acc + (w_bit ? m : 0), except first bit subtracts m (two's complement MSB); counter increments.
REQ-022 ACCUM, w_valid=0: acc and counter hold (stall); no timeout.
REQ-023 Signed accumulator width MANT_W+1; no overflow possible at any legal precision.
REQ-024 After the P-th consumed bit, next state DONE; out_valid=1 from first DONE cycle.
REQ-025 DONE: out_mant = |acc|; out_sign = act[15] XOR (acc<0); out_sign forced 0 when |acc|=0; out_exp = act[14:10].
REQ-026 Outputs stable while out_valid=1 and out_ready=0.
REQ-027 DONE with out_ready=1: return to IDLE next cycle; in_ready stays 0 in that handshake cycle (no bypass).
REQ-028 Latency with w_valid held high: out_valid asserts P+1 cycles after the in_valid/in_ready cycle.
REQ-029 w_valid/w_bit ignored in IDLE and DONE; in_valid ignored outside IDLE.
REQ-030 Throughput: one operation per P+2 cycles minimum.

Reset
REQ-031 rst=1 at any state, including mid-ACCUM: next state IDLE, accumulator/counter cleared, partial result discarded.
REQ-032 Reset values: in_ready=1 after reset, out_valid=0, out_sign=0, out_exp=0, out_mant=0.

Configuration
REQ-033 Macro FP_INT_MUL_UNSIGNED_W_EN defined: adds input port w_unsigned (1 bit), latched with act in IDLE; when 1, the first bit adds rather than subtracts (unsigned weight).
REQ-034 Macro undefined: port w_unsigned absent; weights always two's complement.

Verification
REQ-035 act=0x3C00, precision=4, bits 0,0,1,1 -> out_sign=0, out_exp=15, out_mant=0xC00, out_valid 5 cycles after accept.
REQ-036 act=0xBC00, precision=4, bits 1,0,0,0 (-8) -> out_sign=0, out_mant=0x2000; bits 1,1,1,1 (-1) -> out_sign=0, out_mant=0x400.
REQ-037 act=0x3C00, precision=8, bits 0x80 -> out_sign=1, out_mant=0x20000; act=0x0000, any bits -> out_mant=0, out_sign=0.
REQ-038 w_valid low 3 cycles mid-stream -> result unchanged, out_valid delayed exactly 3 cycles.
REQ-039 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; rst asserted mid-ACCUM -> IDLE next cycle, out_valid=0, no stale result.
REQ-040 With FP_INT_MUL_UNSIGNED_W_EN, w_unsigned=1, act=0x3C00, precision=4, bits 1,1,1,1 -> out_sign=0, out_mant=0x3C00.
